// File: rtl/reaction_timebase.sv
// ---------------------------------------------------------------------------
// reaction_timebase
//   Timing responder for the reaction-test controller. Owns the 1 ms
//   prescaler, the LFSR-randomised pre-stimulus delay and the reaction
//   stopwatch that feeds the display path.
//
// Ports
//   clk           in   system clock
//   rst_n         in   synchronous reset, active low
//   arm           in   level, high while the controller waits for stimulus
//   start_timer   in   1-cycle pulse: zero stopwatch and run
//   stop_timer    in   1-cycle pulse: freeze stopwatch
//   clear         in   1-cycle pulse: stop and zero stopwatch
//   delay_done    out  registered; high once the random delay has elapsed
//   elapsed_time  out  stopwatch value in ms (binary, 14 bits)
//   overflow      out  stopwatch reached MAX_COUNT and saw another tick
//   timing        out  stopwatch running
//   ms_tick       out  1-cycle pulse on the last prescaler count
// ---------------------------------------------------------------------------
module reaction_timebase #(
  parameter int TICK_DIV     = 10000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 11,
  parameter int MAX_COUNT    = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arm,
  input  logic        start_timer,
  input  logic        stop_timer,
  input  logic        clear,
  output logic        delay_done,
  output logic [13:0] elapsed_time,
  output logic        overflow,
  output logic        timing,
  output logic        ms_tick
);

  localparam int PS_W  = $clog2(TICK_DIV);
  localparam int TGT_W = $clog2(MIN_DELAY_MS + (1 << RAND_BITS)) + 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [13:0]     MAX_VAL = 14'(MAX_COUNT);
  localparam logic [15:0]     LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {D_IDLE, D_COUNT, D_DONE} dstate_t;

  logic [PS_W-1:0]  r_presc;
  logic [15:0]      r_lfsr;
  dstate_t          r_state;
  dstate_t          w_state_nxt;
  logic [TGT_W-1:0] r_target;
  logic [TGT_W-1:0] w_target_nxt;
  logic [TGT_W-1:0] r_dcount;
  logic [TGT_W-1:0] w_dcount_nxt;
  logic             r_delay_done;
  logic             w_done_nxt;
  logic [13:0]      r_elapsed;
  logic             r_overflow;
  logic             r_timing;
  logic             w_tick;
  logic             w_arm_start;

  // Galois form, taps x^16+x^14+x^13+x^11+1; a nonzero seed never reaches zero.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  assign w_tick      = (r_presc == PS_LAST);
  assign w_arm_start = (r_state == D_IDLE) && arm;

  // ---- prescaler and LFSR --------------------------------------------------
  // Restarting the prescaler on start/arm makes the first ms a full ms.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_lfsr  <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_step(r_lfsr);
      if (start_timer || w_arm_start || w_tick)
        r_presc <= '0;
      else
        r_presc <= r_presc + 1'b1;
    end
  end

  // ---- delay FSM: state register --------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= D_IDLE;
      r_delay_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_delay_done <= w_done_nxt;
    end
    // target/count are always reloaded in D_IDLE before use
    r_target <= w_target_nxt;
    r_dcount <= w_dcount_nxt;
  end

  // ---- delay FSM: next state ------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_dcount_nxt = r_dcount;
    w_done_nxt   = r_delay_done;
    if (!arm) begin
      w_state_nxt = D_IDLE;
      w_done_nxt  = 1'b0;
    end else begin
      case (r_state)
        D_IDLE: begin
          w_target_nxt = TGT_W'(MIN_DELAY_MS) + TGT_W'(r_lfsr[RAND_BITS-1:0]);
          w_dcount_nxt = '0;
          w_state_nxt  = D_COUNT;
        end
        D_COUNT: begin
          if (w_tick) begin
            w_dcount_nxt = r_dcount + 1'b1;
            // the target-th tick completes the delay
            if (r_dcount == r_target - TGT_W'(1)) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = D_DONE;
            end
          end
        end
        D_DONE:  w_done_nxt  = 1'b1;
        default: w_state_nxt = D_IDLE;
      endcase
    end
  end

  // ---- stopwatch ------------------------------------------------------------
  // Priority: clear > start > stop > tick. Saturates at MAX_VAL, flags overflow.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_elapsed  <= '0;
      r_overflow <= 1'b0;
      r_timing   <= 1'b0;
    end else if (start_timer) begin
      r_elapsed  <= '0;
      r_overflow <= 1'b0;
      r_timing   <= 1'b1;
    end else if (stop_timer) begin
      r_timing <= 1'b0;
    end else if (r_timing && w_tick) begin
      if (r_elapsed == MAX_VAL)
        r_overflow <= 1'b1;
      else
        r_elapsed <= r_elapsed + 1'b1;
    end
  end

  assign delay_done   = r_delay_done;
  assign elapsed_time = r_elapsed;
  assign overflow     = r_overflow;
  assign timing       = r_timing;
  assign ms_tick      = w_tick;

endmodule

// File: tb/tb_reaction_timebase.sv
// ---------------------------------------------------------------------------
// tb_reaction_timebase
//   Self-checking bench for reaction_timebase with small timing parameters.
//   Expected values are queued when stimulus is applied and popped when the
//   corresponding DUT output is sampled (on the falling clock edge).
// ---------------------------------------------------------------------------
module tb_reaction_timebase;

  localparam int TICK_DIV     = 4;
  localparam int MIN_DELAY_MS = 3;
  localparam int RAND_BITS    = 2;
  localparam int MAX_COUNT    = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm;
  logic        start_timer;
  logic        stop_timer;
  logic        clear;
  logic        delay_done;
  logic [13:0] elapsed_time;
  logic        overflow;
  logic        timing;
  logic        ms_tick;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  // reference LFSR, advanced exactly like the design's random source
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  reaction_timebase #(
    .TICK_DIV    (TICK_DIV),
    .MIN_DELAY_MS(MIN_DELAY_MS),
    .RAND_BITS   (RAND_BITS),
    .MAX_COUNT   (MAX_COUNT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm         (arm),
    .start_timer (start_timer),
    .stop_timer  (stop_timer),
    .clear       (clear),
    .delay_done  (delay_done),
    .elapsed_time(elapsed_time),
    .overflow    (overflow),
    .timing      (timing),
    .ms_tick     (ms_tick)
  );

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start_timer = 1'b1;
    @(negedge clk);
    start_timer = 1'b0;
  endtask

  // arm and measure edges from the arm edge to delay_done; -1 on timeout
  task automatic arm_and_measure(output int lat);
    lat = -1;
    arm = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (delay_done === 1'b1) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int ev;
    int k;
    pulse_start();
    k = 0;
    while (elapsed_time !== 14'd5 && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (elapsed_time !== 14'd5) begin
      n_fail++;
      $display("FAIL reset_prerun: got %0d expected 5", elapsed_time);
    end
    rst_n = 1'b0;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(16'hACE1);
    @(negedge clk);
    rst_n = 1'b1;
    ev = exp_q.pop_front(); n_tests++;
    if (elapsed_time !== 14'(ev)) begin
      n_fail++; $display("FAIL reset_elapsed: got %0d expected %0d", elapsed_time, ev);
    end
    ev = exp_q.pop_front(); n_tests++;
    if (overflow !== 1'(ev)) begin
      n_fail++; $display("FAIL reset_overflow: got %0b expected %0d", overflow, ev);
    end
    ev = exp_q.pop_front(); n_tests++;
    if (timing !== 1'(ev)) begin
      n_fail++; $display("FAIL reset_timing: got %0b expected %0d", timing, ev);
    end
    ev = exp_q.pop_front(); n_tests++;
    if (delay_done !== 1'(ev)) begin
      n_fail++; $display("FAIL reset_delay_done: got %0b expected %0d", delay_done, ev);
    end
    ev = exp_q.pop_front(); n_tests++;
    if (ms_tick !== 1'(ev)) begin
      n_fail++; $display("FAIL reset_ms_tick: got %0b expected %0d", ms_tick, ev);
    end
    ev = exp_q.pop_front(); n_tests++;
    if (dut.r_lfsr !== 16'(ev)) begin
      n_fail++; $display("FAIL reset_lfsr: got %h expected %h", dut.r_lfsr, ev);
    end
  endtask

  task automatic test_prescaler();
    int cnt;
    int ev;
    exp_q.push_back(40 / TICK_DIV);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ms_tick === 1'b1) cnt++;
    end
    ev = exp_q.pop_front(); n_tests++;
    if (cnt !== ev) begin
      n_fail++; $display("FAIL prescaler_ticks: got %0d expected %0d", cnt, ev);
    end
  endtask

  task automatic test_delay();
    int lat;
    int ev;
    int r;
    r = int'(m_lfsr[RAND_BITS-1:0]);
    exp_q.push_back(TICK_DIV * (MIN_DELAY_MS + r));
    arm_and_measure(lat);
    ev = exp_q.pop_front(); n_tests++;
    if (lat !== ev) begin
      n_fail++; $display("FAIL delay_latency: got %0d expected %0d", lat, ev);
    end
    n_tests++;
    if (lat < 12 || lat > 24) begin
      n_fail++; $display("FAIL delay_range: got %0d expected 12..24", lat);
    end
    exp_q.push_back(1);
    wait_neg(10);
    ev = exp_q.pop_front(); n_tests++;
    if (delay_done !== 1'(ev)) begin
      n_fail++; $display("FAIL delay_hold: got %0b expected %0d", delay_done, ev);
    end
    arm = 1'b0;
    exp_q.push_back(0);
    @(negedge clk);
    ev = exp_q.pop_front(); n_tests++;
    if (delay_done !== 1'(ev)) begin
      n_fail++; $display("FAIL delay_disarm: got %0b expected %0d", delay_done, ev);
    end
  endtask

  task automatic test_stopwatch();
    int ev;
    pulse_start();
    wait_neg(20);
    stop_timer = 1'b1;
    exp_q.push_back(5); exp_q.push_back(0); exp_q.push_back(5);
    @(negedge clk);
    stop_timer = 1'b0;
    ev = exp_q.pop_front(); n_tests++;
    if (elapsed_time !== 14'(ev)) begin
      n_fail++; $display("FAIL sw_stop_value: got %0d expected %0d", elapsed_time, ev);
    end
    ev = exp_q.pop_front(); n_tests++;
    if (timing !== 1'(ev)) begin
      n_fail++; $display("FAIL sw_stop_timing: got %0b expected %0d", timing, ev);
    end
    wait_neg(40);
    ev = exp_q.pop_front(); n_tests++;
    if (elapsed_time !== 14'(ev)) begin
      n_fail++; $display("FAIL sw_frozen: got %0d expected %0d", elapsed_time, ev);
    end
  endtask

  task automatic test_saturation();
    int ev;
    pulse_start();
    exp_q.push_back(MAX_COUNT); exp_q.push_back(1); exp_q.push_back(1);
    wait_neg(80);
    ev = exp_q.pop_front(); n_tests++;
    if (elapsed_time !== 14'(ev)) begin
      n_fail++; $display("FAIL sat_value: got %0d expected %0d", elapsed_time, ev);
    end
    ev = exp_q.pop_front(); n_tests++;
    if (overflow !== 1'(ev)) begin
      n_fail++; $display("FAIL sat_overflow: got %0b expected %0d", overflow, ev);
    end
    ev = exp_q.pop_front(); n_tests++;
    if (timing !== 1'(ev)) begin
      n_fail++; $display("FAIL sat_timing: got %0b expected %0d", timing, ev);
    end
    clear = 1'b1;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    @(negedge clk);
    clear = 1'b0;
    ev = exp_q.pop_front(); n_tests++;
    if (elapsed_time !== 14'(ev)) begin
      n_fail++; $display("FAIL clear_value: got %0d expected %0d", elapsed_time, ev);
    end
    ev = exp_q.pop_front(); n_tests++;
    if (overflow !== 1'(ev)) begin
      n_fail++; $display("FAIL clear_overflow: got %0b expected %0d", overflow, ev);
    end
    ev = exp_q.pop_front(); n_tests++;
    if (timing !== 1'(ev)) begin
      n_fail++; $display("FAIL clear_timing: got %0b expected %0d", timing, ev);
    end
  endtask

  task automatic test_abort();
    int seen;
    int lat;
    int ev;
    int r;
    seen = 0;
    exp_q.push_back(0);
    arm = 1'b1;
    wait_neg(8);
    arm = 1'b0;
    for (int i = 0; i < 38; i++) begin
      if (delay_done !== 1'b0) seen = 1;
      @(negedge clk);
    end
    ev = exp_q.pop_front(); n_tests++;
    if (seen !== ev) begin
      n_fail++; $display("FAIL abort_no_done: got %0d expected %0d", seen, ev);
    end
    r = int'(m_lfsr[RAND_BITS-1:0]);
    exp_q.push_back(TICK_DIV * (MIN_DELAY_MS + r));
    arm_and_measure(lat);
    arm = 1'b0;
    @(negedge clk);
    ev = exp_q.pop_front(); n_tests++;
    if (lat !== ev) begin
      n_fail++; $display("FAIL abort_rearm_latency: got %0d expected %0d", lat, ev);
    end
  endtask

  task automatic test_collisions();
    int ev;
    int k;
    pulse_start();
    k = 0;
    while (!(elapsed_time === 14'd3 && ms_tick === 1'b1) && k < 100) begin
      @(negedge clk);
      k++;
    end
    stop_timer = 1'b1;
    exp_q.push_back(3); exp_q.push_back(0);
    @(negedge clk);
    stop_timer = 1'b0;
    wait_neg(10);
    ev = exp_q.pop_front(); n_tests++;
    if (elapsed_time !== 14'(ev)) begin
      n_fail++; $display("FAIL stop_on_tick: got %0d expected %0d", elapsed_time, ev);
    end
    ev = exp_q.pop_front(); n_tests++;
    if (timing !== 1'(ev)) begin
      n_fail++; $display("FAIL stop_on_tick_timing: got %0b expected %0d", timing, ev);
    end
    pulse_start();
    wait_neg(10);
    clear = 1'b1;
    start_timer = 1'b1;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    @(negedge clk);
    clear = 1'b0;
    start_timer = 1'b0;
    ev = exp_q.pop_front(); n_tests++;
    if (elapsed_time !== 14'(ev)) begin
      n_fail++; $display("FAIL clear_start_value: got %0d expected %0d", elapsed_time, ev);
    end
    ev = exp_q.pop_front(); n_tests++;
    if (timing !== 1'(ev)) begin
      n_fail++; $display("FAIL clear_start_timing: got %0b expected %0d", timing, ev);
    end
    wait_neg(12);
    ev = exp_q.pop_front(); n_tests++;
    if (elapsed_time !== 14'(ev)) begin
      n_fail++; $display("FAIL clear_start_idle: got %0d expected %0d", elapsed_time, ev);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    arm         = 1'b0;
    start_timer = 1'b0;
    stop_timer  = 1'b0;
    clear       = 1'b0;
    wait_neg(3);
    rst_n = 1'b1;
    @(negedge clk);

    test_reset();
    test_prescaler();
    test_delay();
    test_stopwatch();
    test_saturation();
    test_abort();
    test_collisions();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
